// File: rtl/user_pkg.sv
// rtl/user_pkg.sv - shared types and helpers for the user-ID authentication block
package user_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHECK   = 3'd2,
        S_GRANT   = 3'd3,
        S_DENY    = 3'd4,
        S_LOCK    = 3'd5
    } state_t;

    // Upper bounds on the table slicer operands; instances must stay within them.
    localparam int MAX_ID_W    = 256;
    localparam int MAX_TABLE_W = 4096;

    function automatic int id_width(input int digits, input int digit_w);
        return digits * digit_w;
    endfunction

    // Width of a table index, never below one bit so a single-user table still has a port.
    function automatic int idx_width(input int num_users);
        return (num_users <= 1) ? 1 : $clog2(num_users);
    endfunction

    // Entry k of a flattened table, zero-extended to MAX_ID_W.
    function automatic logic [MAX_ID_W-1:0] table_entry(
        input logic [MAX_TABLE_W-1:0] tbl,
        input int                     id_w,
        input int                     k
    );
        logic [MAX_TABLE_W-1:0] shifted;
        logic [MAX_ID_W-1:0]    mask;
        shifted = tbl >> (k * id_w);
        mask    = {MAX_ID_W{1'b1}} >> (MAX_ID_W - id_w);
        return shifted[MAX_ID_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/id_matcher.sv
// rtl/id_matcher.sv - compares an ID against every enrolled entry, lowest index wins
module id_matcher
    import user_pkg::*;
#(
    parameter int ID_W      = 16,
    parameter int NUM_USERS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [ID_W-1:0]           id,
    input  logic [NUM_USERS*ID_W-1:0] user_table,
    output logic                      hit,
    output logic [IDX_W-1:0]          idx
);

    // Scan from the top index down so the lowest matching entry is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_USERS - 1; k >= 0; k--) begin
            if (ID_W'(table_entry(MAX_TABLE_W'(user_table), ID_W, k)) == id) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/user_id_auth.sv
// rtl/user_id_auth.sv - keypad user-ID entry, table match, grant/deny and lockout
module user_id_auth
    import user_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int NUM_USERS   = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  auth,
    input  logic                                  load_input,
    input  logic                                  clear_input,
    input  logic [DIGIT_W-1:0]                    id_input,
    input  logic [NUM_USERS*DIGITS*DIGIT_W-1:0]   user_table,
    output logic [DIGITS*DIGIT_W-1:0]             id_output,
    output logic [DIGIT_W-1:0]                    user_seg,
    output logic [$clog2(DIGITS+1)-1:0]           digit_count,
    output logic                                  user_allow,
    output logic [idx_width(NUM_USERS)-1:0]       user_idx,
    output logic                                  user_deny,
    output logic                                  locked
);

    localparam int ID_W  = id_width(DIGITS, DIGIT_W);
    localparam int IDX_W = idx_width(NUM_USERS);
    localparam int DC_W  = $clog2(DIGITS + 1);
    localparam int FC_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    state_t             state, state_n;
    logic [ID_W-1:0]    shift_reg;
    logic [FC_W-1:0]    fail_cnt;
    logic [TMR_W-1:0]   timer;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               last_digit;
    logic               timer_done;
    logic               at_max_tries;

    id_matcher #(
        .ID_W      (ID_W),
        .NUM_USERS (NUM_USERS),
        .IDX_W     (IDX_W)
    ) u_matcher (
        .id         (shift_reg),
        .user_table (user_table),
        .hit        (hit),
        .idx        (hit_idx)
    );

    assign last_digit   = (digit_count == DC_W'(DIGITS - 1));
    assign timer_done   = (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign at_max_tries = (fail_cnt == FC_W'(MAX_TRIES));

    // Status outputs decode straight from the state so reset clears them without waiting for an edge.
    assign user_allow = (state == S_GRANT);
    assign user_deny  = (state == S_DENY);
    assign locked     = (state == S_LOCK);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state decode; in COLLECT an auth drop beats clear, clear beats load, load beats the timeout.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (auth && load_input) state_n = (DIGITS == 1) ? S_CHECK : S_COLLECT;
            end
            S_COLLECT: begin
                if (!auth)                          state_n = S_IDLE;
                else if (clear_input)               state_n = S_COLLECT;
                else if (load_input && last_digit)  state_n = S_CHECK;
                else if (!load_input && timer_done) state_n = S_IDLE;
            end
            S_CHECK: state_n = hit ? S_GRANT : S_DENY;
            S_GRANT: begin
                if (!auth) state_n = S_IDLE;
            end
            S_DENY:  state_n = at_max_tries ? S_LOCK : S_IDLE;
            S_LOCK:  state_n = S_LOCK;
            default: state_n = S_IDLE;
        endcase
    end

    // Digit shift register, display digit, counters and the latched grant result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg   <= '0;
            user_seg    <= '0;
            digit_count <= '0;
            id_output   <= '0;
            user_idx    <= '0;
            fail_cnt    <= '0;
            timer       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (auth && load_input) begin
                        shift_reg   <= ID_W'(id_input);
                        user_seg    <= id_input;
                        digit_count <= DC_W'(1);
                        timer       <= '0;
                    end
                end
                S_COLLECT: begin
                    if (!auth || clear_input || (!load_input && timer_done)) begin
                        shift_reg   <= '0;
                        user_seg    <= '0;
                        digit_count <= '0;
                        timer       <= '0;
                    end else if (load_input) begin
                        shift_reg   <= (shift_reg << DIGIT_W) | ID_W'(id_input);
                        user_seg    <= id_input;
                        digit_count <= digit_count + DC_W'(1);
                        timer       <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        id_output <= shift_reg;
                        user_idx  <= hit_idx;
                        fail_cnt  <= '0;
                    end else if (!at_max_tries) begin
                        fail_cnt <= fail_cnt + FC_W'(1);
                    end
                end
                S_GRANT: begin
                    if (!auth) begin
                        shift_reg   <= '0;
                        digit_count <= '0;
                        id_output   <= '0;
                        user_idx    <= '0;
                    end
                end
                S_DENY: begin
                    shift_reg   <= '0;
                    user_seg    <= '0;
                    digit_count <= '0;
                    id_output   <= '0;
                    user_idx    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_user_id_auth.sv
// tb/tb_user_id_auth.sv - scoreboard bench for user_id_auth
module tb_user_id_auth;

    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int NUM_USERS   = 4;
    localparam int MAX_TRIES   = 3;
    localparam int TIMEOUT_CYC = 32;
    localparam int ID_W        = DIGITS * DIGIT_W;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          auth;
    logic                          load_input;
    logic                          clear_input;
    logic [DIGIT_W-1:0]            id_input;
    logic [NUM_USERS*ID_W-1:0]     user_table;
    logic [ID_W-1:0]               id_output;
    logic [DIGIT_W-1:0]            user_seg;
    logic [2:0]                    digit_count;
    logic                          user_allow;
    logic [1:0]                    user_idx;
    logic                          user_deny;
    logic                          locked;

    typedef struct {
        bit              is_grant;
        int              idx;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_allow = 1'b0;
    exp_t got_e;

    user_id_auth #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .NUM_USERS   (NUM_USERS),
        .MAX_TRIES   (MAX_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .auth        (auth),
        .load_input  (load_input),
        .clear_input (clear_input),
        .id_input    (id_input),
        .user_table  (user_table),
        .id_output   (id_output),
        .user_seg    (user_seg),
        .digit_count (digit_count),
        .user_allow  (user_allow),
        .user_idx    (user_idx),
        .user_deny   (user_deny),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DIGIT_W-1:0] d);
        load_input = 1'b1;
        id_input   = d;
        tick();
        load_input = 1'b0;
    endtask

    task automatic enter_id(input logic [ID_W-1:0] id);
        for (int i = DIGITS - 1; i >= 0; i--) strobe(id[i*DIGIT_W +: DIGIT_W]);
    endtask

    task automatic push_exp(input bit g, input int idx, input logic [ID_W-1:0] id);
        exp_t e;
        e.is_grant = g;
        e.idx      = idx;
        e.id       = id;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_sb_pending"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Scoreboard monitor: every grant rising edge and every deny cycle consumes one expectation.
    always @(negedge clk) begin
        if (user_allow && !prev_allow) begin
            if (sb.size() == 0) begin
                check("grant_unexpected", 32'd1, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check("grant_kind", 32'd1, 32'(got_e.is_grant));
                check("grant_idx", 32'(user_idx), 32'(got_e.idx));
                check("grant_id", 32'(id_output), 32'(got_e.id));
            end
        end
        if (user_deny) begin
            if (sb.size() == 0) begin
                check("deny_unexpected", 32'd1, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check("deny_kind", 32'd0, 32'(got_e.is_grant));
                check("deny_allow", 32'(user_allow), 32'd0);
            end
        end
        prev_allow = user_allow;
    end

    initial begin
        rst         = 1'b0;
        auth        = 1'b0;
        load_input  = 1'b0;
        clear_input = 1'b0;
        id_input    = '0;
        user_table  = {16'h9ABC, 16'h1234, 16'h9ABC, 16'h5678};

        // Reset values
        tick();
        check("rst_allow", 32'(user_allow), 32'd0);
        check("rst_deny", 32'(user_deny), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_count", 32'(digit_count), 32'd0);
        check("rst_idout", 32'(id_output), 32'd0);
        check("rst_seg", 32'(user_seg), 32'd0);
        rst = 1'b1;
        tick();

        // 1: ID 1234 matches table[2]
        auth = 1'b1;
        push_exp(1'b1, 2, 16'h1234);
        strobe(4'h1);
        check("t1_count1", 32'(digit_count), 32'd1);
        check("t1_seg1", 32'(user_seg), 32'h1);
        strobe(4'h2);
        strobe(4'h3);
        check("t1_count3", 32'(digit_count), 32'd3);
        check("t1_seg3", 32'(user_seg), 32'h3);
        strobe(4'h4);
        check("t1_allow_in_check", 32'(user_allow), 32'd0);
        wait_sb("t1");
        check("t1_allow", 32'(user_allow), 32'd1);
        auth = 1'b0;
        tick();
        check("t1_drop_allow", 32'(user_allow), 32'd0);
        check("t1_drop_idout", 32'(id_output), 32'd0);
        check("t1_drop_count", 32'(digit_count), 32'd0);

        // 2: clear wins over a simultaneous load, then 5678 matches table[0]
        auth = 1'b1;
        strobe(4'h1);
        strobe(4'h2);
        check("t2_count2", 32'(digit_count), 32'd2);
        clear_input = 1'b1;
        strobe(4'h9);
        clear_input = 1'b0;
        check("t2_clr_count", 32'(digit_count), 32'd0);
        check("t2_clr_seg", 32'(user_seg), 32'd0);
        push_exp(1'b1, 0, 16'h5678);
        enter_id(16'h5678);
        wait_sb("t2");
        auth = 1'b0;
        tick();

        // 4 then 3: one denial, an abandoned entry that must not count, then two more denials to lock
        auth = 1'b1;
        push_exp(1'b0, 0, '0);
        enter_id(16'hFFFF);
        wait_sb("t3_deny1");
        check("t3_locked1", 32'(locked), 32'd0);
        strobe(4'h2);
        strobe(4'h3);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
        check("t4_count_before_tmo", 32'(digit_count), 32'd2);
        tick();
        check("t4_count_after_tmo", 32'(digit_count), 32'd0);
        check("t4_seg_after_tmo", 32'(user_seg), 32'd0);
        push_exp(1'b0, 0, '0);
        enter_id(16'hEEEE);
        wait_sb("t3_deny2");
        check("t3_locked2", 32'(locked), 32'd0);
        push_exp(1'b0, 0, '0);
        enter_id(16'h0000);
        wait_sb("t3_deny3");
        check("t3_locked3", 32'(locked), 32'd1);
        enter_id(16'h1234);
        tick();
        tick();
        check("t3_lock_count", 32'(digit_count), 32'd0);
        check("t3_lock_allow", 32'(user_allow), 32'd0);
        check("t3_lock_held", 32'(locked), 32'd1);
        auth = 1'b0;
        do_reset();
        check("t3_unlock", 32'(locked), 32'd0);

        // 5: duplicate ID resolves to the lower index; loads ignored in GRANT
        auth = 1'b1;
        push_exp(1'b1, 1, 16'h9ABC);
        enter_id(16'h9ABC);
        wait_sb("t5");
        strobe(4'h1);
        check("t5_grant_hold_id", 32'(id_output), 32'h9ABC);
        check("t5_grant_hold_allow", 32'(user_allow), 32'd1);
        auth = 1'b0;
        tick();
        check("t5_drop_allow", 32'(user_allow), 32'd0);

        // 6: asynchronous reset between clock edges mid-entry
        auth = 1'b1;
        strobe(4'h7);
        strobe(4'h8);
        check("t6_count_pre", 32'(digit_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_count", 32'(digit_count), 32'd0);
        check("t6_async_seg", 32'(user_seg), 32'd0);
        check("t6_async_idout", 32'(id_output), 32'd0);
        check("t6_async_flags", 32'({user_allow, user_deny, locked}), 32'd0);
        auth = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
